sram_march_bist: RTL and testbench
==================================

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001: SHALL have parameter ADDR_WIDTH, default 6, giving the SRAM address width (depth 64).
REQ-002: SHALL have parameter DATA_WIDTH, default 24, giving the SRAM word width.
REQ-003: SHALL have port clk, input, 1 bit: the single clock, shared with the SRAM.
REQ-004: SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005: SHALL have port start, input, 1 bit: request to run the test; sampled only in IDLE.
REQ-006: SHALL have port bg, input, DATA_WIDTH bits: data background; logical "0" = bg, logical "1" = ~bg; latched on start.
REQ-007: SHALL have port busy, output, 1 bit: test in progress.
REQ-008: SHALL have port done, output, 1 bit: test complete; sticky until the next accepted start or rst.
REQ-009: SHALL have port fail, output, 1 bit: at least one miscompare occurred this run.
REQ-010: SHALL have port fail_elem, output, 3 bits: march element index of the first miscompare.
REQ-011: SHALL have port fail_addr, output, ADDR_WIDTH bits: address of the first miscompare.
REQ-012: SHALL have port fail_data, output, DATA_WIDTH bits: raw sram_dout at the first miscompare.
REQ-013: SHALL have port err_count, output, 8 bits: miscompare count, saturating.
REQ-014: SHALL have port sram_we, output, 1 bit: SRAM write enable (0 = read).
REQ-015: SHALL have port sram_wmask, output, 1 bit: SRAM write mask.
REQ-016: SHALL have port sram_addr, output, ADDR_WIDTH bits: SRAM address.
REQ-017: SHALL have port sram_din, output, DATA_WIDTH bits: SRAM write data.
REQ-018: SHALL have port sram_dout, input, DATA_WIDTH bits: SRAM read data, valid the cycle after a read is issued.

Function
REQ-019: The FSM SHALL have states IDLE, RUN, DRAIN and DONE; DONE behaves as IDLE but keeps done=1.
REQ-020: When start=1 is sampled in IDLE or DONE at edge k, the block SHALL latch bg, clear done/fail/fail_*/err_count, and enter RUN; busy=1 from edge k.
REQ-021: The block SHALL execute March C- with one SRAM operation per RUN cycle: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 down(r0).
REQ-022: "up" SHALL mean addresses 0..63 and "down" 63..0; for two-operation elements, both operations SHALL complete on an address before moving to the next address.
REQ-023: A RUN SHALL take exactly 640 operation cycles, the first driven in the cycle after edge k.
REQ-024: During writes, sram_we=1, sram_wmask=1 and sram_din=bg or ~bg; during reads, sram_we=0 and sram_wmask=0.
REQ-025: Each read issued in cycle t SHALL compare sram_dout in cycle t+1 against the expected value; the compare result is registered at edge t+1.
REQ-026: Compares SHALL be enabled only for reads the block issued during the current RUN.
REQ-027: On a miscompare, err_count SHALL increment, saturating at 255; fail SHALL be set.
REQ-028: fail_elem, fail_addr and fail_data SHALL be captured on the first miscompare only and then held.
REQ-029: After the last E5 read (address 0), the block SHALL spend one cycle in DRAIN for the final compare, then enter DONE at edge k+641 with busy=0 and done=1.
REQ-030: start SHALL be ignored while busy=1.
REQ-031: Outside RUN, the SRAM outputs SHALL be sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0.

Reset
REQ-032: rst SHALL be sampled on the clk edge and SHALL take priority over all other inputs, including mid-run.
REQ-033: After reset, the state SHALL be IDLE with busy, done, fail, fail_elem, fail_addr, fail_data and err_count all 0, and the SRAM outputs per REQ-031.
REQ-034: SRAM contents SHALL NOT be touched by reset; a reset mid-run SHALL abandon the test with no done.

Verification
REQ-035: Clean run: fault-free SRAM model, bg=0x000000, start pulsed at edge k -> exactly 640 operation cycles, done=1 at edge k+641, fail=0, err_count=0.
REQ-036: Stuck-at fault: sram_dout bit 5 forced to 1 at address 10, bg=0 -> fail=1, fail_elem=1, fail_addr=10, fail_data=0x000020, err_count=3 (the E1, E3 and E5 reads).
REQ-037: Background check: bg=0xA5A5A5 -> the first 64 writes carry 0xA5A5A5, E1 writes carry 0x5A5A5A, and the run passes.
REQ-038: Start while busy: start pulsed at operation cycle 100 -> no restart, and done still asserts at edge k+641.
REQ-039: Reset mid-run: rst at operation cycle 300 -> the next cycle shows all outputs at reset values; a later start runs a full clean test.
REQ-040: Saturation: every read returns ~expected -> err_count=255 at done, with fail_elem=1 and fail_addr=0.

Source files
------------

// File: rtl/sram_march_bist.sv
// March C- built-in self test for a single-port synchronous SRAM.
// Runs one SRAM operation per cycle and checks each read one cycle later.
module sram_march_bist #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bg,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [2:0]            fail_elem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [7:0]            err_count,
  output logic                  sram_we,
  output logic                  sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] bg_q;
  logic [2:0]            elem;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  phase;

  logic                  cmp_valid;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [2:0]            cmp_elem;
  logic [ADDR_WIDTH-1:0] cmp_addr;

  logic down, two_op, op_read, read_one, write_one;
  logic last_addr, addr_done, last_op, accept;

  // E0 and E5 are single-operation elements; E1..E4 are read-then-write.
  assign down      = (elem >= 3'd3);
  assign two_op    = (elem != 3'd0) && (elem != 3'd5);
  assign op_read   = (elem == 3'd5) || (two_op && !phase);
  assign read_one  = (elem == 3'd2) || (elem == 3'd4);
  assign write_one = (elem == 3'd1) || (elem == 3'd3);
  assign last_addr = down ? (addr == '0) : (addr == '1);
  assign addr_done = !two_op || phase;
  assign last_op   = (elem == 3'd5) && last_addr;
  assign accept    = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sram_we    = 1'b0;
    sram_wmask = 1'b0;
    sram_addr  = '0;
    sram_din   = '0;
    case (state)
      IDLE, DONE: if (accept) state_next = RUN;
      RUN: begin
        if (last_op) state_next = DRAIN;
        sram_addr = addr;
        if (!op_read) begin
          sram_we    = 1'b1;
          sram_wmask = 1'b1;
          sram_din   = write_one ? ~bg_q : bg_q;
        end
      end
      DRAIN:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bg_q  <= '0;
      elem  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (accept) begin
      bg_q  <= bg;
      elem  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (state == RUN) begin
      if (!addr_done) begin
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        if (last_addr) begin
          // Elements E3 onward sweep downward from the top address.
          elem <= elem + 3'd1;
          addr <= (elem >= 3'd2) ? '1 : '0;
        end else begin
          addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_elem  <= '0;
      cmp_addr  <= '0;
      fail      <= 1'b0;
      fail_elem <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      err_count <= '0;
    end else begin
      cmp_valid <= (state == RUN) && op_read;
      cmp_exp   <= read_one ? ~bg_q : bg_q;
      cmp_elem  <= elem;
      cmp_addr  <= addr;
      if (accept) begin
        fail      <= 1'b0;
        fail_elem <= '0;
        fail_addr <= '0;
        fail_data <= '0;
        err_count <= '0;
      end else if (cmp_valid && (sram_dout != cmp_exp)) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (!fail) begin
          fail_elem <= cmp_elem;
          fail_addr <= cmp_addr;
          fail_data <= sram_dout;
        end
        fail <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Randomized bench for sram_march_bist: an SRAM model with injectable read faults,
// and a March C- reference built from the element table.
module tb_sram_march_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] bg;
  logic        busy, done, fail;
  logic [2:0]  fail_elem;
  logic [5:0]  fail_addr;
  logic [23:0] fail_data;
  logic [7:0]  err_count;
  logic        sram_we, sram_wmask;
  logic [5:0]  sram_addr;
  logic [23:0] sram_din, sram_dout;

  int test_count = 0;
  int fail_count = 0;

  int         fault_mode = 0;
  logic [5:0] fault_addr = 6'd0;
  int         fault_bit = 0;

  logic [23:0] mem [64];
  logic [23:0] rd_q = 24'h0;
  logic [5:0]  rd_addr_q = 6'd0;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [23:0] data;
  } op_t;

  op_t         ops[$];
  int          exp_err;
  logic        exp_fail;
  logic [2:0]  exp_elem;
  logic [5:0]  exp_addr;
  logic [23:0] exp_data;
  logic [23:0] din_first, din_e1w;

  sram_march_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .start(start), .bg(bg),
    .busy(busy), .done(done), .fail(fail),
    .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data),
    .err_count(err_count),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Fault applied on the SRAM read port only; stored contents stay intact.
  function automatic logic [23:0] apply_fault(input logic [5:0] a, input logic [23:0] v);
    case (fault_mode)
      1:       return (a == fault_addr) ? (v | (24'h1 << fault_bit)) : v;
      2:       return ~v;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (sram_we && sram_wmask) mem[sram_addr] <= sram_din;
    else if (!sram_we) rd_q <= mem[sram_addr];
    rd_addr_q <= sram_addr;
  end

  assign sram_dout = apply_fault(rd_addr_q, rd_q);

  function automatic string march_elem(input int e);
    case (e)
      0:       return "w0";
      1:       return "r0w1";
      2:       return "r1w0";
      3:       return "r0w1";
      4:       return "r1w0";
      default: return "r0";
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
    end
  endtask

  // Walk March C- over an ideal memory seen through the fault, recording ops and first error.
  task automatic build_model(input logic [23:0] b);
    logic [23:0] mm [64];
    logic [23:0] val, obs;
    logic [5:0]  a;
    string       s;
    op_t         op;
    ops.delete();
    exp_err  = 0;
    exp_fail = 1'b0;
    exp_elem = 3'd0;
    exp_addr = 6'd0;
    exp_data = 24'h0;
    for (int e = 0; e < 6; e++) begin
      s = march_elem(e);
      for (int k = 0; k < 64; k++) begin
        a = (e >= 3) ? 6'(63 - k) : 6'(k);
        for (int j = 0; j < s.len(); j += 2) begin
          val = (s[j+1] == "1") ? ~b : b;
          if (s[j] == "w") begin
            op.we = 1'b1; op.addr = a; op.data = val;
            mm[a] = val;
          end else begin
            op.we = 1'b0; op.addr = a; op.data = 24'h0;
            obs = apply_fault(a, mm[a]);
            if (obs != val) begin
              if (exp_err < 255) exp_err++;
              if (!exp_fail) begin
                exp_fail = 1'b1;
                exp_elem = 3'(e);
                exp_addr = a;
                exp_data = obs;
              end
            end
          end
          ops.push_back(op);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_status"},
                64'({busy, done, fail, fail_elem, fail_addr, fail_data, err_count}), 64'd0);
    checkOutput({tag, "_sram"}, 64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'd0);
  endtask

  task automatic applyStimulus(input logic [23:0] b, input int start_at, input int reset_at);
    op_t o;
    build_model(b);
    @(negedge clk);
    bg    = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bg    = 24'($urandom);
    checkOutput("busy_at_start", 64'({busy, done, fail, err_count}), 64'({1'b1, 1'b0, 1'b0, 8'd0}));
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      o = ops[i];
      checkOutput($sformatf("op%0d", i),
                  64'({busy, done, sram_we, sram_wmask, sram_addr, sram_din}),
                  64'({1'b1, 1'b0, o.we, o.we, o.addr, o.data}));
      if (i == 0)  din_first = sram_din;
      if (i == 65) din_e1w   = sram_din;
      if (i == start_at) begin
        start = 1'b1;
        bg    = ~b;
      end else begin
        start = 1'b0;
      end
      if (i == reset_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midrun_reset");
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("drain_busy_done", 64'({busy, done}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    checkOutput("end_busy_done", 64'({busy, done}), 64'({1'b0, 1'b1}));
    checkOutput("end_fail", 64'(fail), 64'(exp_fail));
    checkOutput("end_err_count", 64'(err_count), 64'(exp_err));
    checkOutput("end_fail_elem", 64'(fail_elem), 64'(exp_elem));
    checkOutput("end_fail_addr", 64'(fail_addr), 64'(exp_addr));
    checkOutput("end_fail_data", 64'(fail_data), 64'(exp_data));
    checkOutput("end_sram_idle", 64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bg    = 24'h0;
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    check_reset_values("idle");

    fault_mode = 0;
    applyStimulus(24'h000000, -1, -1);

    applyStimulus(24'hA5A5A5, -1, -1);
    checkOutput("bg_first_write", 64'(din_first), 64'(24'hA5A5A5));
    checkOutput("bg_e1_write", 64'(din_e1w), 64'(24'h5A5A5A));

    fault_mode = 1; fault_addr = 6'd10; fault_bit = 5;
    applyStimulus(24'h000000, -1, -1);
    checkOutput("stuck_fail", 64'(fail), 64'd1);
    checkOutput("stuck_elem", 64'(fail_elem), 64'd1);
    checkOutput("stuck_addr", 64'(fail_addr), 64'd10);
    checkOutput("stuck_data", 64'(fail_data), 64'h20);
    checkOutput("stuck_err_count", 64'(err_count), 64'd3);

    fault_mode = 0;
    applyStimulus(24'($urandom), 100, -1);

    fault_mode = 1;
    applyStimulus(24'h000000, -1, 300);
    repeat (2) @(negedge clk);
    check_reset_values("after_reset_idle");
    fault_mode = 0;
    applyStimulus(24'($urandom), -1, -1);

    fault_mode = 2;
    applyStimulus(24'($urandom), -1, -1);
    checkOutput("sat_err_count", 64'(err_count), 64'd255);
    checkOutput("sat_elem", 64'(fail_elem), 64'd1);
    checkOutput("sat_addr", 64'(fail_addr), 64'd0);

    for (int r = 0; r < 3; r++) begin
      fault_mode = 1;
      fault_addr = 6'($urandom_range(0, 63));
      fault_bit  = int'($urandom_range(0, 23));
      applyStimulus(24'($urandom), -1, -1);
    end

    fault_mode = 0;
    applyStimulus(24'($urandom), -1, -1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
